// File: rtl/uart_pkg.sv
// Shared UART constants and types for the receive path.
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// DEPTH x byte register array: one synchronous write port, one combinational read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  uart_byte_t        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output uart_byte_t        rdata
);

    // Contents are deliberately not reset; readers gate on rd_valid.
    uart_byte_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver, with sticky overrun flag.
// Optional: define UART_RX_FIFO_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH  = UART_RX_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  uart_byte_t       rx_data,
    input  logic             rx_done,
    output uart_byte_t       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [ADDR_W:0]  count,
    output logic             full,
    output logic             empty,
`ifdef UART_RX_FIFO_OVERRUN_CNT_EN
    output logic [7:0]       overrun_cnt,
`endif
    output logic             overrun,
    input  logic             overrun_clr
);

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            overrun_q, overrun_d;

    logic rd_fire;
    logic wr_fire;
    logic ovr_evt;

    // Status comes from registered pointers only, so no input reaches these flags combinationally.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                      (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign rd_valid = !empty;

    assign rd_fire = rd_valid & rd_ready;
    assign wr_fire = rx_done & (!full | rd_fire);
    assign ovr_evt = rx_done & full & !rd_fire;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A new drop beats a same-cycle clear.
        if (ovr_evt) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign count   = count_q;
    assign overrun = overrun_q;

`ifdef UART_RX_FIFO_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (overrun_clr) begin
            ovr_cnt_d = ovr_evt ? 8'd1 : 8'd0;
        end else if (ovr_evt && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_cnt_q <= '0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign overrun_cnt = ovr_cnt_q;
`endif

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (rx_data),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (rd_data)
    );

endmodule : uart_rx_fifo

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each byte the receiver presents with its one-cycle `rx_done` strobe and queues it in a first-word-fall-through FIFO. Bytes drain through a valid/ready read port toward the MIC-1 I/O register logic. Bytes that arrive while the FIFO is full are dropped and flagged as overrun.

## Interface
- `DEPTH`, 16: number of byte slots; must be a power of two and at least 2.
- `ADDR_W`, $clog2(DEPTH): pointer index width. Derived; never overridden.

- `clk`, input, 1: single system clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `rx_data`, input, 8: byte from the receiver; valid only in a cycle where `rx_done` is 1.
- `rx_done`, input, 1: one-cycle strobe marking a completed byte.
- `rd_data`, output, 8: head-of-queue byte; valid whenever `rd_valid` is 1.
- `rd_valid`, output, 1: FIFO is not empty.
- `rd_ready`, input, 1: consumer accepts the head byte in this cycle.
- `count`, output, ADDR_W+1: number of bytes held, 0..DEPTH.
- `full`, output, 1: `count` == DEPTH.
- `empty`, output, 1: `count` == 0.
- `overrun`, output, 1: sticky flag; at least one byte was dropped.
- `overrun_clr`, input, 1: clears `overrun`.

## Operation
- Pointers `wr_ptr` and `rd_ptr` are ADDR_W+1 bits wide.
  - Storage is addressed by the low ADDR_W bits.
  - The MSB is a wrap bit. `empty` is true when the pointers are equal; `full` is true when the low bits are equal and the MSBs differ.
  - Pointers wrap modulo 2·DEPTH with no special handling.
- Read fire: `rd_valid & rd_ready`. `rd_ptr` increments. `rd_ready` while empty is ignored.
- Write fire: `rx_done & (!full | read fire)`. `rx_data` is stored at `wr_ptr` and `wr_ptr` increments.
- Write and read fire in the same cycle:
  - `count` is unchanged.
  - When full, the read frees the slot and the write is accepted; there is no overrun.
  - When empty, no read fires because `rd_valid` is 0.
- Overrun: `rx_done & full & !read fire`.
  - The byte is discarded and the pointers hold.
  - `overrun` is set on the next edge.
- `overrun_clr` clears `overrun`. When `overrun_clr` and a new overrun occur in the same cycle, set wins.
- `count` is a register updated as +1, -1, or 0. It must always equal `wr_ptr - rd_ptr`.
- `rd_data` is the storage output at `rd_ptr[ADDR_W-1:0]`. It is a combinational read of registered storage; no extra register stage.

## Timing
- Reset values:
  - `wr_ptr` = `rd_ptr` = 0
  - `count` = 0
  - `empty` = 1
  - `full` = 0
  - `rd_valid` = 0
  - `overrun` = 0
- `rd_data` is undefined after reset until the first write. Storage contents are not reset.
- Write latency: a byte strobed at edge N gives `rd_valid` = 1 and the correct `rd_data` in the cycle after edge N.
- `rd_data` advances to the next byte in the cycle after a read fire.
- `full`, `empty`, and `rd_valid` are registered or derived from registered pointers only. They have no combinational path from `rx_done` or `rd_ready`.
- `rst` asserted mid-operation empties the FIFO at that edge. An `rx_done` in the same cycle is lost.
- Back-to-back `rx_done` on consecutive cycles must be accepted, even though the receiver never produces them.

## Configuration
- `UART_RX_FIFO_OVERRUN_CNT_EN` defined:
  - Adds output `overrun_cnt` [7:0], a count of dropped bytes that saturates at 255.
  - Reset value is 0. It is cleared by `overrun_clr`; a same-cycle drop loads 1.
- Not defined: the port and counter are absent. Only the sticky `overrun` flag exists.

## Structure
- Package `uart_pkg` holds:
  - `UART_DATA_W` = 8
  - typedef `uart_byte_t` (logic [UART_DATA_W-1:0])
  - the default-depth constant `UART_RX_FIFO_DEPTH` = 16
- Sub-module `uart_fifo_mem`: DEPTH × 8 register array with one write port (`we`, `waddr`, `wdata`) and a combinational read port (`raddr`, `rdata`).
- All pointer, count, flag, and overrun logic stays in `uart_rx_fifo`.

## Test plan
- After reset, strobe 0x55 once. `rd_valid` = 1 and `rd_data` = 0x55 on the following cycle. With `rd_ready` = 1 for one cycle, `empty` returns to 1.
- Write 0x00..0x0F with `rd_ready` = 0 (DEPTH = 16). Then `full` = 1 and `count` = 16. A 17th strobe of 0xAA sets `overrun`, and the data read back is 0x00..0x0F in order.
- With the FIFO full, strobe 0xBB while `rd_ready` = 1. Then `overrun` stays 0, `count` stays 16, and 0xBB appears after the original 16 bytes.
- Run 40 bytes through with random `rd_ready` stalls to exercise pointer wrap. All bytes must come out in order, and `count` must match the scoreboard every cycle.
- Cause an overrun, then assert `overrun_clr` together with another overrun. `overrun` stays 1. Assert `overrun_clr` alone and `overrun` reads 0 on the next cycle. With the macro defined, `overrun_cnt` goes 1 → 1 → 0.
- Assert `rst` with 5 bytes queued and `rx_done` = 1 in the same cycle. The next cycle shows `empty` = 1, `count` = 0, and `rd_valid` = 0.
